programmable_echo_line: RTL and testbench

//  Parametrised audio delay line with run-time delay, wet/dry mix and optional feedback (multi-echo).

---
 rtl/echo_pkg.sv | 29 ++
 rtl/echo_sat_mac.sv | 32 +++
 rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv | 40 ++++
 rtl/programmable_echo_line.sv | 174 +++++++++++++++++
 tb/tb_programmable_echo_line.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/echo_pkg.sv
// Shared types and helpers for the programmable echo line: FSM states, BRAM read latency and
// a generic saturating narrowing function.
package echo_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdWait,
    StRdData,
    StMixWr
  } echo_state_e;

  localparam int unsigned BRAM_LATENCY = 2;

  // Clamp a 32-bit signed value to the range of a w-bit signed number.
  function automatic logic [31:0] sat(input logic signed [31:0] x, input int unsigned w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/echo_sat_mac.sv
// Combinational saturating multiply-accumulate: result = sat(acc + (sample * gain) >>> GAIN_W),
// with gain treated as an unsigned fraction of 2^GAIN_W.
module echo_sat_mac
  import echo_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned GAIN_W = 8
) (
  input  logic signed [DATA_W-1:0] acc,
  input  logic signed [DATA_W-1:0] sample,
  input  logic        [GAIN_W-1:0] gain,
  output logic signed [DATA_W-1:0] result
);

  localparam int unsigned PW = DATA_W + GAIN_W + 1;

  logic signed [PW-1:0] sample_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic signed [31:0]   sum;

  always_comb begin
    sample_ext = {{(GAIN_W + 1){sample[DATA_W-1]}}, sample};
    gain_ext   = {{(DATA_W + 1){1'b0}}, gain};
    prod       = sample_ext * gain_ext;
    shifted    = prod >>> GAIN_W;
    sum        = {{(32 - PW){shifted[PW-1]}}, shifted} + {{(32 - DATA_W){acc[DATA_W-1]}}, acc};
    result     = DATA_W'(sat(sum, DATA_W));
  end

endmodule

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// Dual-clock block RAM model, read-first, with the output register enabled (2-cycle read latency).
// Port A is used for writes and port B for reads in this design.
module xilinx_true_dual_port_read_first_2_clock_ram #(
  parameter int unsigned RAM_WIDTH = 18,
  parameter int unsigned RAM_DEPTH = 1024
) (
  input  logic                         clka,
  input  logic                         clkb,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         wea,
  input  logic                         ena,
  input  logic                         enb,
  input  logic                         rstb,
  input  logic                         regceb,
  output logic [RAM_WIDTH-1:0]         doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_b;

  always_ff @(posedge clka) begin
    if (ena && wea) begin
      mem[addra] <= dina;
    end
  end

  always_ff @(posedge clkb) begin
    if (enb) begin
      ram_data_b <= mem[addrb];
    end
    if (rstb) begin
      doutb <= '0;
    end else if (regceb) begin
      doutb <= ram_data_b;
    end
  end

endmodule

// File: rtl/programmable_echo_line.sv
// Audio delay line with run-time delay, wet/dry mix and, when ECHO_FEEDBACK_EN is defined,
// feedback of the delayed sample into the line for a decaying echo train.
module programmable_echo_line
  import echo_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 48000,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned GAIN_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              audio_valid_in,
  input  logic [DATA_W-1:0] audio_in,
  input  logic              store_audio_in,
  input  logic [ADDR_W-1:0] delay_in,
  input  logic [GAIN_W-1:0] wet_gain_in,
  input  logic [GAIN_W-1:0] fb_gain_in,
  output logic [DATA_W-1:0] signal_out,
  output logic [DATA_W-1:0] echo_out,
  output logic              valid_out,
  output logic              busy_out,
  output logic              overrun_out
);

  localparam int unsigned       BA_W      = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] MAX_DELAY = ADDR_W'(DEPTH - 1);
  localparam logic [BA_W-1:0]   LAST_IDX  = BA_W'(DEPTH - 1);

  echo_state_e state_q;

  logic signed [DATA_W-1:0] dry_q;
  logic                     store_q;
  logic [GAIN_W-1:0]        wet_gain_q;
  logic [BA_W-1:0]          d_q;
  logic [BA_W-1:0]          wr_ptr_q;
  logic [BA_W-1:0]          fill_cnt_q;
  logic [DATA_W-1:0]        wr_data_q;

  logic [BA_W-1:0]          rd_addr;
  logic [DATA_W-1:0]        rd_data;
  logic signed [DATA_W-1:0] delayed;
  logic signed [DATA_W-1:0] mix;
  logic signed [DATA_W-1:0] base_x;
  logic signed [DATA_W-1:0] wr_data_d;
  logic                     wr_en;

  // Wrap without a modulo; the true result is always below DEPTH, so mod-2^BA_W math is exact.
  always_comb begin
    if (wr_ptr_q >= d_q) begin
      rd_addr = wr_ptr_q - d_q;
    end else begin
      rd_addr = wr_ptr_q + BA_W'(DEPTH) - d_q;
    end
  end

  // Until the line has seen d samples the slot behind wr_ptr holds nothing meaningful.
  assign delayed = (fill_cnt_q < d_q) ? '0 : rd_data;
  assign base_x  = store_q ? dry_q : '0;
  assign wr_en   = (state_q == StMixWr);

  echo_sat_mac #(
    .DATA_W(DATA_W),
    .GAIN_W(GAIN_W)
  ) u_wet_mac (
    .acc   (dry_q),
    .sample(delayed),
    .gain  (wet_gain_q),
    .result(mix)
  );

`ifdef ECHO_FEEDBACK_EN
  logic [GAIN_W-1:0] fb_gain_q;

  echo_sat_mac #(
    .DATA_W(DATA_W),
    .GAIN_W(GAIN_W)
  ) u_fb_mac (
    .acc   (base_x),
    .sample(delayed),
    .gain  (fb_gain_q),
    .result(wr_data_d)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fb_gain_q <= '0;
    end else if (state_q == StIdle && audio_valid_in) begin
      fb_gain_q <= fb_gain_in;
    end
  end
`else
  logic unused_fb_gain;
  assign unused_fb_gain = ^fb_gain_in;
  assign wr_data_d      = base_x;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= StIdle;
      dry_q       <= '0;
      store_q     <= 1'b0;
      wet_gain_q  <= '0;
      d_q         <= BA_W'(1);
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      wr_data_q   <= '0;
      signal_out  <= '0;
      echo_out    <= '0;
      valid_out   <= 1'b0;
      busy_out    <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (audio_valid_in && busy_out) begin
        overrun_out <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (audio_valid_in) begin
            dry_q      <= audio_in;
            store_q    <= store_audio_in;
            wet_gain_q <= wet_gain_in;
            if (delay_in == '0) begin
              d_q <= BA_W'(1);
            end else if (delay_in > MAX_DELAY) begin
              d_q <= LAST_IDX;
            end else begin
              d_q <= delay_in[BA_W-1:0];
            end
            busy_out <= 1'b1;
            state_q  <= StRdIssue;
          end
        end
        StRdIssue: state_q <= StRdWait;
        StRdWait:  state_q <= StRdData;
        StRdData: begin
          signal_out <= mix;
          echo_out   <= delayed;
          wr_data_q  <= wr_data_d;
          valid_out  <= 1'b1;
          state_q    <= StMixWr;
        end
        StMixWr: begin
          wr_ptr_q <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + BA_W'(1);
          if (fill_cnt_q != LAST_IDX) begin
            fill_cnt_q <= fill_cnt_q + BA_W'(1);
          end
          busy_out <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  xilinx_true_dual_port_read_first_2_clock_ram #(
    .RAM_WIDTH(DATA_W),
    .RAM_DEPTH(DEPTH)
  ) u_bram (
    .clka  (clk_in),
    .clkb  (clk_in),
    .addra (wr_ptr_q),
    .addrb (rd_addr),
    .dina  (wr_data_q),
    .wea   (wr_en),
    .ena   (1'b1),
    .enb   (1'b1),
    .rstb  (1'b0),
    .regceb(1'b1),
    .doutb (rd_data)
  );

endmodule

// File: tb/tb_programmable_echo_line.sv
// Directed bench for programmable_echo_line with a 16-deep line and 8-bit gains.
module tb_programmable_echo_line;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned GAIN_W = 8;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              audio_valid_in;
  logic [DATA_W-1:0] audio_in;
  logic              store_audio_in;
  logic [ADDR_W-1:0] delay_in;
  logic [GAIN_W-1:0] wet_gain_in;
  logic [GAIN_W-1:0] fb_gain_in;
  logic [DATA_W-1:0] signal_out;
  logic [DATA_W-1:0] echo_out;
  logic              valid_out;
  logic              busy_out;
  logic              overrun_out;

  always #5 clk_in = ~clk_in;

  programmable_echo_line #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .GAIN_W(GAIN_W)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .audio_valid_in(audio_valid_in),
    .audio_in      (audio_in),
    .store_audio_in(store_audio_in),
    .delay_in      (delay_in),
    .wet_gain_in   (wet_gain_in),
    .fb_gain_in    (fb_gain_in),
    .signal_out    (signal_out),
    .echo_out      (echo_out),
    .valid_out     (valid_out),
    .busy_out      (busy_out),
    .overrun_out   (overrun_out)
  );

  typedef struct {
    bit rst;
    int audio;
    bit store;
    int delay;
    int wet;
    int exp_echo;
    int exp_sig;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    rst_n_in       = 1'b0;
    audio_valid_in = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  // Strobe one sample; lat is the cycle (strobe cycle = 0) in which valid_out is seen, -1 if never.
  task automatic do_sample(input int audio, input bit store, input int delay, input int wet,
                           input int fb, output int echo, output int sig, output int lat);
    @(posedge clk_in);
    #1;
    audio_in       = 16'(audio);
    store_audio_in = store;
    delay_in       = 16'(delay);
    wet_gain_in    = 8'(wet);
    fb_gain_in     = 8'(fb);
    audio_valid_in = 1'b1;
    lat  = -1;
    echo = 0;
    sig  = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_in);
      #1;
      if (k == 1) audio_valid_in = 1'b0;
      if (valid_out) begin
        lat  = k;
        echo = int'($signed(echo_out));
        sig  = int'($signed(signal_out));
        break;
      end
    end
    repeat (2) @(posedge clk_in);
  endtask

  initial begin
    int echo, sig, lat, pulses;
    int fb_exp[7];
    int fb_in[7];

    rst_n_in       = 1'b0;
    audio_valid_in = 1'b0;
    audio_in       = '0;
    store_audio_in = 1'b1;
    delay_in       = '0;
    wet_gain_in    = '0;
    fb_gain_in     = '0;

    repeat (3) @(posedge clk_in);
    #1;
    check("reset signal_out", int'(signal_out), 0);
    check("reset echo_out", int'(echo_out), 0);
    check("reset valid_out", int'(valid_out), 0);
    check("reset busy_out", int'(busy_out), 0);
    check("reset overrun_out", int'(overrun_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Impulse through a 4-sample delay at near-unity wet gain.
    vecs.push_back('{1, 1000, 1, 4, 255, 0, 1000});
    vecs.push_back('{0, 0, 1, 4, 255, 0, 0});
    vecs.push_back('{0, 0, 1, 4, 255, 0, 0});
    vecs.push_back('{0, 0, 1, 4, 255, 0, 0});
    vecs.push_back('{0, 0, 1, 4, 255, 1000, 996});
    vecs.push_back('{0, 0, 1, 4, 255, 0, 0});
    // Ramp through the maximum delay, crossing the write-pointer wrap twice.
    for (int i = 0; i < 40; i++) begin
      vecs.push_back('{(i == 0), i + 1, 1, 15, 128, (i >= 15) ? i - 14 : 0,
                       (i >= 15) ? (i + 1) + ((i - 14) / 2) : i + 1});
    end
    // Oversized delay clamps to DEPTH-1.
    vecs.push_back('{0, 41, 1, 100, 128, 26, 54});
    // Saturation, silence writes and zero-delay clamp.
    vecs.push_back('{1, 30000, 1, 1, 255, 0, 30000});
    vecs.push_back('{0, 30000, 1, 1, 255, 30000, 32767});
    vecs.push_back('{0, -30000, 1, 1, 255, 30000, -118});
    vecs.push_back('{0, -30000, 1, 1, 255, -30000, -32768});
    vecs.push_back('{0, 500, 0, 1, 255, -30000, -29383});
    vecs.push_back('{0, 7, 1, 1, 255, 0, 7});
    vecs.push_back('{0, 9, 1, 0, 255, 7, 15});

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      do_sample(vecs[i].audio, vecs[i].store, vecs[i].delay, vecs[i].wet, 0, echo, sig, lat);
      check($sformatf("vec%0d latency", i), lat, 4);
      check($sformatf("vec%0d echo_out", i), echo, vecs[i].exp_echo);
      check($sformatf("vec%0d signal_out", i), sig, vecs[i].exp_sig);
    end

    // Feedback: delay 2, half-gain recirculation of a 1024 impulse.
    fb_in = '{1024, 0, 0, 0, 0, 0, 0};
`ifdef ECHO_FEEDBACK_EN
    fb_exp = '{0, 0, 1024, 0, 512, 0, 256};
`else
    fb_exp = '{0, 0, 1024, 0, 0, 0, 0};
`endif
    do_reset();
    for (int i = 0; i < 7; i++) begin
      do_sample(fb_in[i], 1, 2, 0, 128, echo, sig, lat);
      check($sformatf("feedback s%0d echo_out", i), echo, fb_exp[i]);
    end

    // Overrun: second strobe two cycles after the first is dropped and flagged.
    do_reset();
    check("overrun clear after reset", int'(overrun_out), 0);
    @(posedge clk_in);
    #1;
    audio_in       = 16'd5;
    store_audio_in = 1'b1;
    delay_in       = 16'd1;
    wet_gain_in    = 8'd0;
    audio_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    audio_valid_in = 1'b0;
    @(posedge clk_in);
    #1;
    audio_in       = 16'd77;
    audio_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    audio_valid_in = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (valid_out) pulses++;
      @(posedge clk_in);
      #1;
    end
    check("overrun valid pulses", pulses, 1);
    check("overrun flag set", int'(overrun_out), 1);
    do_sample(6, 1, 1, 0, 0, echo, sig, lat);
    check("overrun dropped sample not stored", echo, 5);
    check("overrun flag sticky", int'(overrun_out), 1);

    // Reset asserted while the read is in flight.
    @(posedge clk_in);
    #1;
    audio_in       = 16'd2222;
    delay_in       = 16'd1;
    audio_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    audio_valid_in = 1'b0;
    @(posedge clk_in);
    #1;
    check("pre-abort busy_out", int'(busy_out), 1);
    rst_n_in = 1'b0;
    #1;
    check("abort signal_out", int'(signal_out), 0);
    check("abort echo_out", int'(echo_out), 0);
    check("abort busy_out", int'(busy_out), 0);
    check("abort overrun_out", int'(overrun_out), 0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    do_sample(10, 1, 1, 0, 0, echo, sig, lat);
    check("post-abort prefill echo", echo, 0);
    check("post-abort latency", lat, 4);
    do_sample(20, 1, 1, 0, 0, echo, sig, lat);
    check("post-abort echo", echo, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
